// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter: two requester channels,
// one valid/ready response channel and the debug operation counter.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              req0_valid;
    logic [3:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req0_ready;

    logic              req1_valid;
    logic [3:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req1_ready;

    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic              rsp_ready;

    logic [CNT_W-1:0]  op_count;

    // Requesters and response consumer
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        output rsp_ready,
        input  op_count
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        input  rsp_ready,
        output op_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters.
// One operation in flight: IDLE (grant) -> EXEC (one ALU cycle) -> RESP
// (hold registered result until consumed). Counts consumed operations.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic         clock,
    input logic         reset,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_NOR = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;

    logic [1:0]        state;
    logic              last_grant;
    logic [3:0]        controle;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic [CNT_W-1:0]  op_count;

    logic              grant_valid;
    logic              grant_id;
    logic [DATA_W-1:0] saida;
    logic              zero;
    logic              op_defined;

    // Grant selection: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_valid & ~grant_id;
    assign bus.req1_ready = grant_valid &  grant_id;

    // Internal ALU driven from the latched operation; undefined codes yield 0
    always_comb begin
        saida      = '0;
        op_defined = 1'b1;
        case (controle)
            OP_ADD:  saida = op_a + op_b;
            OP_SUB:  saida = op_a - op_b;
            OP_AND:  saida = op_a & op_b;
            OP_OR:   saida = op_a | op_b;
            OP_NOR:  saida = ~(op_a | op_b);
            OP_XOR:  saida = op_a ^ op_b;
            OP_SLT:  saida = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            default: op_defined = 1'b0;
        endcase
        zero = (saida == '0);
    end

    // Control FSM, operand latch, response registers and consumed-op counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            controle   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        controle   <= grant_id ? bus.req1_op : bus.req0_op;
                        op_a       <= grant_id ? bus.req1_a  : bus.req0_a;
                        op_b       <= grant_id ? bus.req1_b  : bus.req0_b;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= saida;
                    rsp_zero   <= zero;
                    rsp_err    <= ~op_defined;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_zero   = rsp_zero;
    assign bus.rsp_err    = rsp_err;
    assign bus.op_count   = op_count;
endmodule
